// File: rtl/minaret_mem_arbiter.sv
// Purpose : shares the minaret single memory port between instruction fetch (I) and data (D).
// Latency : grant one cycle after the request edge; response one cycle after the mem_rvalid edge.
// Backpres: mem_ready stalls the issue phase indefinitely; requesters hold req until their gnt.
//
// Port summary:
//   clk, reset                  clock and asynchronous active-low reset
//   i_req/i_addr/i_flush        fetch request side; i_gnt, i_rvalid, i_rdata back to fetch
//   d_req/d_we/d_addr/...       load/store request side; d_gnt, d_rvalid, d_rdata back to data
//   mem_req/mem_we/mem_addr/... memory request (held until mem_ready); mem_rvalid/mem_rdata response
//
// One transaction is outstanding at a time: IDLE (arbitrate) -> ISSUE (offer to memory)
// -> WAIT (await response) -> IDLE. D has fixed priority, except that after STARVE_MAX
// consecutive D grants with I waiting, I is forced to win the next arbitration.
module minaret_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   // instruction fetch requester
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   // data load/store requester
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wmask,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   // shared memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0] state;
   logic       owner;
   logic [3:0] starve_cnt;
   logic       drop_q;      // pending fetch response must be discarded

   logic in_idle;
   logic i_starved;
   logic d_win;
   logic i_win;
   logic flush_hit;
   logic resp_edge;

   assign in_idle   = (state == ST_IDLE);
   // I has waited through STARVE_MAX back-to-back D grants and still wants the port
   assign i_starved = i_req && (starve_cnt == STARVE_LIM);
   assign d_win     = in_idle && d_req && !i_starved;
   assign i_win     = in_idle && !d_win && i_req;
   // a flush only matters while a fetch is actually in flight
   assign flush_hit = i_flush && (owner == OWN_I) &&
                      ((state == ST_ISSUE) || (state == ST_WAIT));
   assign resp_edge = (state == ST_WAIT) && mem_rvalid;

   // ------------------------------------------------------------------
   // Sequencer and memory request registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         owner     <= OWN_I;
         i_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else begin
         i_gnt <= 1'b0;
         d_gnt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (d_win) begin
                  state     <= ST_ISSUE;
                  owner     <= OWN_D;
                  d_gnt     <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_wmask <= d_wmask;
               end else if (i_win) begin
                  state     <= ST_ISSUE;
                  owner     <= OWN_I;
                  i_gnt     <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  mem_wmask <= 4'b1111;
               end
            end
            ST_ISSUE: begin
               // fields stay put after acceptance; only mem_req drops
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Anti-starvation counter: counts D grants taken while I was waiting
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (in_idle) begin
         if (d_win && i_req) begin
            if (starve_cnt != STARVE_LIM) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end else begin
            // I granted, or I not asking: the streak is broken
            starve_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Fetch flush: remember to swallow the response of a redirected fetch
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_q <= 1'b0;
      end else if (resp_edge) begin
         drop_q <= 1'b0;
      end else if (flush_hit) begin
         drop_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Response routing back to the owner
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_rvalid <= 1'b0;
         i_rdata  <= '0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         if (resp_edge) begin
            if (owner == OWN_D) begin
               d_rvalid <= 1'b1;
               // stores are acknowledged with zero data
               d_rdata  <= mem_we ? 32'd0 : mem_rdata;
            end else if (!(drop_q || i_flush)) begin
               // a flush on the response edge itself also kills the response
               i_rvalid <= 1'b1;
               i_rdata  <= mem_rdata;
            end
         end
      end
   end

endmodule
